// File: rtl/best_arr_streamer_if.sv
// Bundles the streamer's control, index-memory read and output-FIFO write signals.
// The master side is the streamer; the slave side is its environment.
interface best_arr_streamer_if #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 9
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  fifo_wenq;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic                  fifo_wfull_n;

    modport master (
        input  start,
        output busy,
        output done,
        output mem_ren,
        output mem_raddr,
        input  mem_rdata,
        output fifo_wenq,
        output fifo_wdata,
        input  fifo_wfull_n
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  mem_ren,
        input  mem_raddr,
        output mem_rdata,
        input  fifo_wenq,
        input  fifo_wdata,
        output fifo_wfull_n
    );
endinterface

// File: rtl/best_arr_streamer.sv
// Streams all best-match indices from the index memory into the output FIFO in
// blocked host order (half-image, column block, row, column within block).
module best_arr_streamer #(
    parameter int DATA_WIDTH = 11,
    parameter int ROW_SIZE   = 26,
    parameter int COL_SIZE   = 19,
    parameter int BLOCKING   = 4,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
    input  logic                clk,
    input  logic                rst,
    best_arr_streamer_if.master bus
);
    localparam int HALF  = ROW_SIZE / 2;
    localparam int NXB   = (HALF + BLOCKING - 1) / BLOCKING;
    localparam int LASTW = HALF - (NXB - 1) * BLOCKING;
    localparam int XW    = (NXB > 1) ? $clog2(NXB) : 1;
    localparam int YW    = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
    localparam int IW    = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

    localparam logic [XW-1:0] X_ZERO = XW'(0);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [XW-1:0] X_LAST = XW'(NXB - 1);
    localparam logic [YW-1:0] Y_ZERO = YW'(0);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [YW-1:0] Y_LAST = YW'(COL_SIZE - 1);
    localparam logic [IW-1:0] XI_ZERO      = IW'(0);
    localparam logic [IW-1:0] XI_ONE       = IW'(1);
    localparam logic [IW-1:0] XI_FULL_LAST = IW'(BLOCKING - 1);
    localparam logic [IW-1:0] XI_TAIL_LAST = IW'(LASTW - 1);
    localparam logic [ADDR_WIDTH-1:0] A_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_ROW  = ADDR_WIDTH'(ROW_SIZE);
    localparam logic [ADDR_WIDTH-1:0] A_BLK  = ADDR_WIDTH'(BLOCKING);
    localparam logic [ADDR_WIDTH-1:0] A_HALF = ADDR_WIDTH'(HALF);
    localparam logic [DATA_WIDTH-1:0] D_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_r, state_s;
    logic   busy_r, done_r;

    logic                  px_r, px_s;
    logic [XW-1:0]         x_r, x_s;
    logic [YW-1:0]         y_r, y_s;
    logic [IW-1:0]         xi_r, xi_s;
    logic [ADDR_WIDTH-1:0] blk_base_r, blk_base_s;
    logic [ADDR_WIDTH-1:0] line_base_r, line_base_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;

    logic [DATA_WIDTH-1:0] buf_r [0:1];
    logic                  wr_ptr_r, rd_ptr_r, inflight_r;
    logic [1:0]            cnt_r, cnt_s, held_s;
    logic                  pop_s, ren_s, last_pos_s;
    logic [IW-1:0]         xi_last_s;

    // Occupancy counts the head leaving this cycle so a steady stream keeps one read per cycle.
    always_comb begin
        pop_s      = (cnt_r != 2'd0) && bus.fifo_wfull_n;
        held_s     = cnt_r - {1'b0, pop_s};
        ren_s      = (state_r == STREAM) && ((held_s + {1'b0, inflight_r}) < 2'd2);
        cnt_s      = held_s + {1'b0, inflight_r};
        xi_last_s  = (x_r == X_LAST) ? XI_TAIL_LAST : XI_FULL_LAST;
        last_pos_s = px_r && (x_r == X_LAST) && (y_r == Y_LAST) && (xi_r == XI_TAIL_LAST);
    end

    // Address generator: innermost xi, then y, then x, then px; bases replace multipliers.
    always_comb begin
        px_s        = px_r;
        x_s         = x_r;
        y_s         = y_r;
        xi_s        = xi_r;
        blk_base_s  = blk_base_r;
        line_base_s = line_base_r;
        addr_s      = addr_r;
        if (ren_s) begin
            if (xi_r != xi_last_s) begin
                xi_s   = xi_r + XI_ONE;
                addr_s = addr_r + A_ONE;
            end else if (y_r != Y_LAST) begin
                xi_s        = XI_ZERO;
                y_s         = y_r + Y_ONE;
                line_base_s = line_base_r + A_ROW;
                addr_s      = line_base_r + A_ROW;
            end else if (x_r != X_LAST) begin
                xi_s        = XI_ZERO;
                y_s         = Y_ZERO;
                x_s         = x_r + X_ONE;
                blk_base_s  = blk_base_r + A_BLK;
                line_base_s = blk_base_r + A_BLK;
                addr_s      = blk_base_r + A_BLK;
            end else if (!px_r) begin
                xi_s        = XI_ZERO;
                y_s         = Y_ZERO;
                x_s         = X_ZERO;
                px_s        = 1'b1;
                blk_base_s  = A_HALF;
                line_base_s = A_HALF;
                addr_s      = A_HALF;
            end else begin
                xi_s        = XI_ZERO;
                y_s         = Y_ZERO;
                x_s         = X_ZERO;
                px_s        = 1'b0;
                blk_base_s  = A_ZERO;
                line_base_s = A_ZERO;
                addr_s      = A_ZERO;
            end
        end else begin
            addr_s = addr_r;
        end
    end

    // Next-state logic; start outside IDLE is ignored.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_s = STREAM;
                else           state_s = IDLE;
            end
            STREAM: begin
                if (ren_s && last_pos_s) state_s = DRAIN;
                else                     state_s = STREAM;
            end
            DRAIN: begin
                if ((held_s == 2'd0) && !inflight_r) state_s = DONE;
                else                                 state_s = DRAIN;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, status outputs and address counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            px_r        <= 1'b0;
            x_r         <= X_ZERO;
            y_r         <= Y_ZERO;
            xi_r        <= XI_ZERO;
            blk_base_r  <= A_ZERO;
            line_base_r <= A_ZERO;
            addr_r      <= A_ZERO;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s == STREAM) || (state_s == DRAIN);
            done_r      <= (state_s == DONE);
            px_r        <= px_s;
            x_r         <= x_s;
            y_r         <= y_s;
            xi_r        <= xi_s;
            blk_base_r  <= blk_base_s;
            line_base_r <= line_base_s;
            addr_r      <= addr_s;
        end
    end

    // Two-entry skid buffer: capture returning read data, pop on enqueue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_r[0]   <= D_ZERO;
            buf_r[1]   <= D_ZERO;
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            cnt_r      <= 2'd0;
            inflight_r <= 1'b0;
        end else begin
            if (inflight_r) begin
                buf_r[wr_ptr_r] <= bus.mem_rdata;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            cnt_r      <= cnt_s;
            inflight_r <= ren_s;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.mem_ren    = ren_s;
    assign bus.mem_raddr  = addr_r;
    assign bus.fifo_wenq  = pop_s;
    assign bus.fifo_wdata = buf_r[rd_ptr_r];
endmodule

// File: tb/tb_best_arr_streamer.sv
// Directed bench for best_arr_streamer: memory responder plus a scoreboard of
// expected words queued at read issue and compared at FIFO enqueue.
module tb_best_arr_streamer;
    localparam int DW   = 11;
    localparam int RS   = 26;
    localparam int CS   = 19;
    localparam int BL   = 4;
    localparam int NQ   = RS * CS;
    localparam int AW   = $clog2(NQ);
    localparam int HALF = RS / 2;
    localparam int NXB  = (HALF + BL - 1) / BL;
    localparam int LW   = HALF - (NXB - 1) * BL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    best_arr_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    best_arr_streamer #(
        .DATA_WIDTH(DW), .ROW_SIZE(RS), .COL_SIZE(CS), .BLOCKING(BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] mem [NQ];
    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] got_q [$];
    int checks   = 0;
    int failures = 0;

    // Index memory: one-cycle read latency, garbage when not reading.
    always @(posedge clk) begin
        if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_raddr];
        else             bus.mem_rdata <= DW'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic build_expected();
        exp_addr_q.delete();
        for (int px = 0; px < 2; px++)
            for (int x = 0; x < NXB; x++)
                for (int y = 0; y < CS; y++)
                    for (int xi = 0; xi < ((x == NXB - 1) ? LW : BL); xi++)
                        exp_addr_q.push_back(AW'(px * HALF + y * RS + x * BL + xi));
    endtask

    function automatic logic wfull_for(input int mode, input int k);
        if (mode == 1) begin
            if (k >= 5 && k <= 40) return 1'b0;
            else if (k > 40)       return k[0];
            else                   return 1'b1;
        end else if (mode == 2) begin
            return 1'($urandom_range(0, 1));
        end else begin
            return 1'b1;
        end
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_mem_ren"}, bus.mem_ren, 0);
        chk({tag, "_fifo_wenq"}, bus.fifo_wenq, 0);
        chk({tag, "_mem_raddr"}, bus.mem_raddr, 0);
        chk({tag, "_fifo_wdata"}, bus.fifo_wdata, 0);
    endtask

    // mode: 0 = FIFO always ready, 1 = stall window then alternating, 2 = random.
    task automatic run(input int mode, input bit extra_starts, input int rst_after);
        int k = -1, enq_n = 0, first_k = -1, last_k = -1, done_n = 0, done_k = -1;
        int outstanding;
        bit fin = 1'b0;
        bit aborted = 1'b0;
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        build_expected();
        sb_q.delete();
        got_q.delete();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.fifo_wfull_n = 1'b1;
        while (!fin) begin
            @(posedge clk); k++; #1;
            bus.start = extra_starts && (k == 10 || k == 300 || k == 496);
            bus.fifo_wfull_n = wfull_for(mode, k);
            if (rst_after > 0 && enq_n == rst_after) begin
                rst = 1'b1;
                bus.start = 1'b0;
                bus.fifo_wfull_n = 1'b1;
                #1;
                check_idle_outputs("rst_mid_stream");
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk); #1;
                    if (i == 1) rst = 1'b0;
                    #1;
                    chk("no_enq_after_rst", bus.fifo_wenq, 0);
                    chk("idle_after_rst", bus.busy, 0);
                end
                aborted = 1'b1;
                fin = 1'b1;
            end else begin
                #1;
                if (k == 0) chk("busy_after_start", bus.busy, 1);
                outstanding = sb_q.size() - (bus.fifo_wenq ? 1 : 0);
                if (bus.fifo_wenq) begin
                    chk("wenq_while_full", bus.fifo_wfull_n, 1);
                    if (sb_q.size() == 0) chk("spurious_enq", 1, 0);
                    else begin
                        e = sb_q.pop_front();
                        chk("wdata", bus.fifo_wdata, e);
                    end
                    got_q.push_back(bus.fifo_wdata);
                    enq_n++;
                    if (first_k < 0) first_k = k;
                    last_k = k;
                end
                if (bus.mem_ren) begin
                    chk("ren_limit", outstanding < 2, 1);
                    if (exp_addr_q.size() == 0) chk("extra_read", 1, 0);
                    else begin
                        a = exp_addr_q.pop_front();
                        chk("raddr", bus.mem_raddr, a);
                        sb_q.push_back(mem[a]);
                    end
                end
                if (bus.done) begin
                    done_n++;
                    if (done_n == 1) begin
                        done_k = k;
                        chk("done_after_last_enq", k, last_k + 1);
                        chk("enq_count", enq_n, NQ);
                        chk("sb_empty", sb_q.size(), 0);
                        chk("busy_in_done", bus.busy, 0);
                    end
                end
                if (done_n > 0 && k > done_k) chk("idle_after_done", bus.busy, 0);
                if (done_n > 0 && k >= done_k + 3) fin = 1'b1;
                if (k > 20000) begin
                    chk("timeout", 0, 1);
                    fin = 1'b1;
                end
            end
        end
        bus.start = 1'b0;
        if (!aborted) begin
            chk("done_pulses", done_n, 1);
            if (mode == 0) begin
                chk("first_enq_latency", first_k, 2);
                chk("last_enq_cycle", last_k, first_k + NQ - 1);
            end
        end
    endtask

    initial begin
        int idx [19] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 75, 76, 228, 246, 247, 248, 249, 250, 251, 493};
        int val [19] = '{0, 1, 2, 3, 26, 27, 28, 29, 52, 471, 4, 12, 480, 13, 14, 15, 16, 39, 493};
        rst = 1'b1;
        bus.start = 1'b0;
        bus.fifo_wfull_n = 1'b1;
        for (int i = 0; i < NQ; i++) mem[i] = DW'(i);
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("idle");

        // Identity memory, FIFO always ready: order, spot values, latency, throughput.
        run(0, 1'b0, 0);
        chk("seq_len", got_q.size(), NQ);
        if (got_q.size() == NQ)
            for (int i = 0; i < 19; i++) chk($sformatf("seq[%0d]", idx[i]), got_q[idx[i]], val[i]);

        // Backpressure window then alternating not-full.
        run(1, 1'b0, 0);

        // Extra start pulses while busy and in the DONE cycle.
        run(0, 1'b1, 0);

        // Reset after the 100th enqueue, then a clean restart from address 0.
        run(0, 1'b0, 100);
        run(0, 1'b0, 0);
        chk("restart_first_word", got_q.size() > 0 ? got_q[0] : 32'hFFFF, 0);

        // Random contents and random backpressure over three runs.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NQ; i++) mem[i] = DW'($urandom);
            run(2, 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/best_arr_streamer.md
Name: best_arr_streamer

Overview:
Output stage between the best-match index memory and the output FIFO write port.
- A single `start` pulse (driven from `send_best_arr`) makes it read all NUM_QUERYS best-match indices.
- Indices are read in the blocked output order consumed by the host, half-image by half-image.
- Each index is enqueued into the async output FIFO, honouring FIFO backpressure.
- Sustains one enqueue per cycle when the FIFO is not full.

Parameters:
- DATA_WIDTH, 11, width of one stored index / FIFO word
- ROW_SIZE, 26, image columns; must be even
- COL_SIZE, 19, image rows
- BLOCKING, 4, column block width
- NUM_QUERYS, ROW_SIZE*COL_SIZE, total indices streamed
- ADDR_WIDTH, $clog2(NUM_QUERYS), index memory address width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begin streaming
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last word is accepted by the FIFO
- mem_ren  out  1  index memory read enable
- mem_raddr  out  ADDR_WIDTH  index memory read address
- mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_ren
- fifo_wenq  out  1  FIFO enqueue
- fifo_wdata  out  DATA_WIDTH  FIFO write data
- fifo_wfull_n  in  1  FIFO not full

Behaviour:
- Clock and reset: one clock (`clk`); reset (`rst`) is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0, buffer empty. Reset may be asserted mid-stream; it aborts with no further enqueue.
- Derived constants:
  - HALF = ROW_SIZE/2
  - NXB = ceil(HALF/BLOCKING)
  - LASTW = HALF-(NXB-1)*BLOCKING
  - Defaults give HALF=13, NXB=4, LASTW=1.
- Address generator: nested counters, outermost first: px 0..1, x 0..NXB-1, y 0..COL_SIZE-1, xi 0..(x==NXB-1 ? LASTW-1 : BLOCKING-1).
- Address formula: addr = px*HALF + y*ROW_SIZE + x*BLOCKING + xi. Computed from counters with ADDR_WIDTH arithmetic; no multiplier on the critical path is required (incremental adds allowed).
- Total words = 2*COL_SIZE*HALF = NUM_QUERYS (494 at defaults).
- State machine:
  - IDLE: start=1 → STREAM, busy=1 in the next cycle.
  - STREAM: issue reads while any remain; when all are issued → DRAIN.
  - DRAIN: when the buffer is empty and there are no reads in flight → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Read issue rule: mem_ren=1 only when (buffered words + reads in flight) < 2. Each issued read advances the counters by one.
- Data path: mem_rdata is captured into a 2-entry FIFO skid buffer the cycle after mem_ren.
- Enqueue rule: fifo_wenq=1 iff the buffer is non-empty AND fifo_wfull_n=1. fifo_wdata = buffer head, combinational from registers. The head pops on the same edge.
- Data integrity:
  - No word is dropped or duplicated under any fifo_wfull_n pattern.
  - Order is strictly the generator order.
  - fifo_wenq is never asserted while fifo_wfull_n=0.
- Latency: first fifo_wenq at the earliest 2 cycles after the start edge (read cycle, capture cycle).
- Throughput: with fifo_wfull_n held 1, the last enqueue occurs NUM_QUERYS+1 cycles after the first read.
- start while busy (including the DONE cycle): ignored.
- Simultaneous start and rst: rst wins.
- Buffer full (2 entries) with FIFO full: mem_ren held 0, counters frozen, mem_raddr holds its value.

Test Plan:
1. Memory preloaded mem[a]=a, fifo_wfull_n=1, start pulse. Required response:
   - Enqueued sequence begins 0,1,2,3,26,27,28,29,52,…,468,469,470,471,4,5,6,7,30,…
   - x=3 words are 12,38,…,480.
   - Second half begins 13,14,15,16,39.
   - Last word 493; exactly 494 enqueues.
   - done one cycle after the last enqueue.
2. Same preload with fifo_wfull_n=0 for cycles 5–40 after start and alternating 1/0 afterwards → identical 494-word sequence, no enqueue while full, mem_ren=0 once 2 words are buffered.
3. Throughput: fifo_wfull_n=1 constantly → the first enqueue is 2 cycles after start and the 494 enqueues are on consecutive cycles.
4. Extra start pulses at cycles 10 and 300 while busy → no restart, sequence and count unchanged, exactly one done pulse.
5. Assert rst after the 100th enqueue → all outputs 0 immediately, no further enqueues. A new start then restarts from address 0 with the full 494-word sequence.
6. Random mem contents plus random fifo_wfull_n (50%) over 3 back-to-back runs → the scoreboard matches mem[addr] in generator order every run.
